sdram_port_arb: RTL and testbench

- Two-port request arbiter sitting directly upstream of sdram_ctl.
- Port 0 serves the CPU data path (read/write); port 1 serves a read-only client (video/DMA).
- Grants one single-word transaction at a time, drives sdram_ctl's addr/write_en/data_in/refresh_data, waits for data_ready, and returns read data with a one-cycle ack pulse to the granted port.
- Guards against a hung controller with a timeout and a sticky error flag.

---
 rtl/sdram_port_arb_if.sv | 42 ++++
 rtl/sdram_port_arb.sv | 103 ++++++++++
 tb/tb_sdram_port_arb.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arb_if.sv
// Bundle of the two requester ports and the sdram_ctl-facing signals.
// The arbiter attaches through the slave modport; requesters and the
// controller sit on the master side.
interface sdram_port_arb_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic [ADDR_W-1:0] p1_addr;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_go;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_data_ready;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_addr,
    input  mem_data_out, mem_data_ready,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_addr, mem_write_en, mem_data_in, mem_go
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_addr,
    output mem_data_out, mem_data_ready,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_addr, mem_write_en, mem_data_in, mem_go
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Two-port round-robin arbiter in front of sdram_ctl. One single-word
// transaction at a time; a hung controller is cut off by a timeout that
// returns 16'hDEAD to the requester and raises a sticky err.
//
// state     | meaning
// IDLE      | waiting for controller ready and a request
// ISSUE     | mem_go pulse to the controller
// WAIT_BUSY | waiting for the controller to drop data_ready
// WAIT_DONE | waiting for data_ready to return, then capture data_out
// RESP      | one-cycle ack to the granted port
module sdram_port_arb #(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  sdram_port_arb_if.slave bus,
  output logic            err
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] RDATA_DEAD = DATA_W'(16'hDEAD);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;  // 1 = port 1; also names the port in flight
  logic [CNT_W-1:0] tmo_cnt;
  logic             grant, grant_p1, tmo_hit, done_ok, done_tmo;

  // grant selection and completion decode
  always_comb begin
    grant    = (state == IDLE) && bus.mem_data_ready && (bus.p0_req || bus.p1_req);
    grant_p1 = bus.p1_req && (!bus.p0_req || !last_grant);
    tmo_hit  = (tmo_cnt == CNT_LAST);
    done_ok  = (state == WAIT_DONE) && bus.mem_data_ready;
    // a real completion wins over a timeout landing in the same cycle
    done_tmo = tmo_hit && ((state == WAIT_BUSY) ||
                           ((state == WAIT_DONE) && !bus.mem_data_ready));
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (done_tmo)                 state_nxt = RESP;
        else if (!bus.mem_data_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (done_ok || done_tmo) state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // registered request fields, handshake outputs, timeout counter and err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant       <= 1'b1;
      tmo_cnt          <= '0;
      err              <= 1'b0;
      bus.mem_go       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_write_en <= 1'b0;
      bus.mem_data_in  <= '0;
      bus.p0_ack       <= 1'b0;
      bus.p1_ack       <= 1'b0;
      bus.p0_rdata     <= '0;
      bus.p1_rdata     <= '0;
    end else begin
      bus.mem_go <= grant;
      bus.p0_ack <= (done_ok || done_tmo) && !last_grant;
      bus.p1_ack <= (done_ok || done_tmo) && last_grant;
      if (grant) begin
        last_grant       <= grant_p1;
        tmo_cnt          <= '0;
        bus.mem_addr     <= grant_p1 ? bus.p1_addr : bus.p0_addr;
        bus.mem_write_en <= !grant_p1 && bus.p0_we;
        bus.mem_data_in  <= grant_p1 ? '0 : bus.p0_wdata;
      end else if ((state == WAIT_BUSY) || (state == WAIT_DONE)) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (done_ok) begin
        if (last_grant) bus.p1_rdata <= bus.mem_data_out;
        else            bus.p0_rdata <= bus.mem_data_out;
      end
      if (done_tmo) begin
        err <= 1'b1;
        if (last_grant) bus.p1_rdata <= RDATA_DEAD;
        else            bus.p0_rdata <= RDATA_DEAD;
      end
    end
  end
endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a behavioural sdram_ctl stand-in, a driver that
// predicts issue/ack expectations from a reference memory and the
// round-robin rule, and a monitor that checks every mem_go and every ack.
module tb_sdram_port_arb;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int TMO = 16;

  logic clk, rst, err;

  sdram_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err(err)
  );

  typedef struct { logic chk; logic [DW-1:0] data; } ack_t;
  typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] din; } iss_t;

  ack_t q0[$], q1[$];
  iss_t q_iss[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int go_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, go_cyc = 0, ack_cyc = 0;
  bit hang = 0;
  int lat_fix = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none/other (cycle %0d)", name, cyc);
  endtask

  // sdram_ctl stand-in: init delay, drops ready after mem_go, returns later
  initial begin
    int phase, ccnt;
    logic hang_op, c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_din;
    bus.mem_data_ready = 0;
    bus.mem_data_out   = '0;
    phase = 0; ccnt = 5; hang_op = 0; c_we = 0; c_addr = '0; c_din = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mem_data_ready = 0;
        phase = 0;
        ccnt  = 5;
      end else begin
        case (phase)
          0: if (ccnt == 0) begin bus.mem_data_ready = 1; phase = 1; end
             else ccnt--;
          1: if (bus.mem_go) begin
               bus.mem_data_ready = 0;
               c_addr = bus.mem_addr; c_we = bus.mem_write_en; c_din = bus.mem_data_in;
               hang_op = hang;
               ccnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(6, 1));
               phase = 2;
             end
          default: begin
            if (hang_op) begin
              if (!hang) begin bus.mem_data_ready = 1; phase = 1; end
            end else if (ccnt == 0) begin
              if (c_we) ctl_mem[c_addr] = c_din;
              else bus.mem_data_out = ctl_mem.exists(c_addr) ? ctl_mem[c_addr] : '0;
              bus.mem_data_ready = 1;
              phase = 1;
            end else ccnt--;
          end
        endcase
      end
    end
  end

  // monitor: every mem_go and every ack is matched against the scoreboard
  initial begin
    ack_t a;
    iss_t s;
    forever begin
      @(negedge clk);
      if (bus.p0_ack || bus.p1_ack) chk("ack_exclusive", bus.p0_ack & bus.p1_ack, 0);
      if (bus.p0_ack) begin
        ack0_cnt++;
        ack_cyc = cyc;
        if (q0.size() == 0) fail_now("p0_unexpected_ack");
        else begin
          a = q0.pop_front();
          if (a.chk) chk("p0_rdata", bus.p0_rdata, a.data);
        end
      end
      if (bus.p1_ack) begin
        ack1_cnt++;
        ack_cyc = cyc;
        if (q1.size() == 0) fail_now("p1_unexpected_ack");
        else begin
          a = q1.pop_front();
          if (a.chk) chk("p1_rdata", bus.p1_rdata, a.data);
        end
      end
      if (bus.mem_go) begin
        go_cnt++;
        go_cyc = cyc;
        if (q_iss.size() == 0) fail_now("unexpected_mem_go");
        else begin
          s = q_iss.pop_front();
          chk("mem_addr", bus.mem_addr, s.addr);
          chk("mem_write_en", bus.mem_write_en, s.we);
          chk("mem_data_in", bus.mem_data_in, s.din);
        end
      end
    end
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] addr);
    return ref_mem.exists(addr) ? ref_mem[addr] : '0;
  endfunction

  function automatic iss_t mk_iss(input bit port, input bit we, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wd);
    iss_t s;
    s.addr = addr;
    s.we   = port ? 1'b0 : we;
    s.din  = port ? '0 : wd;
    return s;
  endfunction

  task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit expect_dead);
    ack_t a;
    bit seen;
    seen = 0;
    @(negedge clk);
    a.chk  = expect_dead || !we;
    a.data = expect_dead ? DW'(16'hDEAD) : ref_rd(addr);
    q_iss.push_back(mk_iss(port, we, addr, wd));
    if (port) begin
      q1.push_back(a);
      bus.p1_addr = addr;
      bus.p1_req  = 1;
    end else begin
      q0.push_back(a);
      bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd;
      bus.p0_req = 1;
    end
    if (!port && we && !expect_dead) ref_mem[addr] = wd;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = port ? bus.p1_ack : bus.p0_ack;
    end
    if (!seen) fail_now("txn_ack_timeout");
    bus.p0_req = 0;
    bus.p1_req = 0;
  endtask

  initial begin
    int a0, a1, g0, n0, n1;
    bit done;
    ack_t a;
    rst = 0;
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_addr = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_p0_ack", bus.p0_ack, 0);
    chk("rst_p1_ack", bus.p1_ack, 0);
    chk("rst_mem_go", bus.mem_go, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_err", err, 0);
    rst = 1;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin @(negedge clk); done = bus.mem_data_ready; end
    if (!done) fail_now("ctl_init_timeout");

    // p0 write then read back, p1 untouched
    a0 = ack0_cnt; a1 = ack1_cnt;
    do_txn(0, 1, 0, 16'h00ff, 0);
    do_txn(0, 0, 0, 16'h0000, 0);
    chk("p0_ack_count", ack0_cnt - a0, 2);
    chk("p1_ack_count", ack1_cnt - a1, 0);

    // p0 write, p1 read of the same word
    do_txn(0, 1, 1, 16'h00fe, 0);
    do_txn(1, 0, 1, 16'h0000, 0);

    // both ports reading continuously from reset: grants 0,1,0,1
    @(negedge clk);
    rst = 0;
    bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 16'h1234; bus.p1_addr = 1;
    bus.p0_req = 1; bus.p1_req = 1;
    for (int k = 0; k < 2; k++) begin
      q_iss.push_back(mk_iss(0, 0, 0, 16'h1234));
      q_iss.push_back(mk_iss(1, 0, 1, 16'h0000));
      a.chk = 1; a.data = ref_rd(0); q0.push_back(a);
      a.chk = 1; a.data = ref_rd(1); q1.push_back(a);
    end
    repeat (2) @(negedge clk);
    rst = 1;
    n0 = 0; n1 = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (bus.p0_ack) n0++;
      if (bus.p1_ack) n1++;
      if (n0 >= 2) bus.p0_req = 0;
      if (n1 >= 2) bus.p1_req = 0;
      done = (n0 >= 2) && (n1 >= 2);
    end
    if (!done) fail_now("round_robin_timeout");
    bus.p0_req = 0; bus.p1_req = 0;

    // p0_req held across an ack: second transaction to the same address
    g0 = go_cnt;
    @(negedge clk);
    bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 16'h0055;
    for (int k = 0; k < 2; k++) begin
      q_iss.push_back(mk_iss(0, 0, 0, 16'h0055));
      a.chk = 1; a.data = ref_rd(0); q0.push_back(a);
    end
    bus.p0_req = 1;
    n0 = 0;
    for (int i = 0; i < 400 && n0 < 2; i++) begin
      @(negedge clk);
      if (bus.p0_ack) n0++;
    end
    bus.p0_req = 0;
    chk("held_req_acks", n0, 2);
    chk("held_req_go_pulses", go_cnt - g0, 2);

    // randomized single-requester traffic
    for (int k = 0; k < 24; k++) begin
      bit port, we;
      port = 1'($urandom_range(1, 0));
      we   = port ? 1'b0 : 1'($urandom_range(1, 0));
      do_txn(port, we, AW'($urandom_range(15, 8)), DW'($urandom), 0);
    end
    chk("err_before_timeout", err, 0);

    // hung controller: DEAD returned 17 cycles after ISSUE, sticky err
    hang = 1;
    do_txn(0, 0, 3, 16'h0000, 1);
    chk("timeout_latency", ack_cyc - go_cyc, TMO + 1);
    chk("err_after_timeout", err, 1);
    hang = 0;
    do_txn(1, 0, 0, 16'h0000, 0);
    do_txn(0, 0, 1, 16'h0000, 0);
    chk("err_sticky", err, 1);

    // reset during WAIT_DONE aborts without an ack
    lat_fix = 10;
    @(negedge clk);
    q_iss.push_back(mk_iss(0, 0, 1, 16'h0000));
    bus.p0_we = 0; bus.p0_addr = 1; bus.p0_wdata = 16'h0000; bus.p0_req = 1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); done = bus.mem_go; end
    if (!done) fail_now("abort_go_timeout");
    repeat (2) @(negedge clk);
    a0 = ack0_cnt; a1 = ack1_cnt;
    rst = 0;
    #1;
    chk("abort_p0_ack", bus.p0_ack, 0);
    chk("abort_p1_ack", bus.p1_ack, 0);
    chk("abort_p0_rdata", bus.p0_rdata, 0);
    chk("abort_p1_rdata", bus.p1_rdata, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_mem_write_en", bus.mem_write_en, 0);
    chk("abort_mem_data_in", bus.mem_data_in, 0);
    chk("abort_mem_go", bus.mem_go, 0);
    chk("abort_err", err, 0);
    bus.p0_req = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    lat_fix = 0;
    repeat (20) @(negedge clk);
    chk("abort_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
    do_txn(0, 0, 0, 16'h0000, 0);
    chk("err_after_reset", err, 0);

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("iss_drained", q_iss.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
